// File: rtl/usrt_rx_ctrl.sv
// rtl/usrt_rx_ctrl.sv - USRT receive frame controller (optional error counters: USRT_RX_ERRCNT_EN)
module usrt_rx_ctrl #(
   parameter int DATA_BITS = 8,
   parameter int CNT_W     = 8
) (
   input  logic                 i_Pclk,
   input  logic                 i_Rst_n,
   input  logic                 i_Enable,
   input  logic                 i_SampleEn,
   input  logic                 i_Rx,
   input  logic [1:0]           i_Parity,
   input  logic                 i_Ready,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   output logic                 o_ParityErr,
   output logic                 o_FrameErr,
   output logic                 o_Overrun,
   output logic                 o_Busy,
   output logic [CNT_W-1:0]     o_ParityErrCnt,
   output logic [CNT_W-1:0]     o_FrameErrCnt
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [1:0]           r_cfg;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_acc;
   logic                 r_perr;
   logic                 r_busy;

   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_perr_h;
   logic                 r_ferr_h;
   logic                 r_ovr;

   logic                 w_step;
   logic                 w_par_en;
   logic                 w_last_bit;
   logic                 w_acc_par;
   logic                 w_complete;
   logic                 w_frame_err;
   logic                 w_load;

   // A bit is consumed only on an enabled strobe
   assign w_step      = i_Enable & i_SampleEn;
   // Parity is used for modes 01 (even) and 10 (odd); 00/11 mean none
   assign w_par_en    = (r_cfg == 2'b01) | (r_cfg == 2'b10);
   assign w_last_bit  = (r_idx == IDX_W'(DATA_BITS - 1));
   assign w_acc_par   = r_acc ^ i_Rx;
   assign w_frame_err = ~i_Rx;
   // Holding register may take the new frame when empty or being drained this cycle
   assign w_load      = w_complete & (~r_valid | i_Ready);

   // State register
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and frame-completion decode
   always_comb begin
      w_next     = r_state;
      w_complete = 1'b0;
      if (!i_Enable) begin
         w_next = S_IDLE;
      end else if (i_SampleEn) begin
         case (r_state)
            S_IDLE: begin
               if (!i_Rx) begin
                  w_next = S_DATA;
               end
            end
            S_DATA: begin
               if (w_last_bit) begin
                  w_next = w_par_en ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               w_next = S_STOP;
            end
            S_STOP: begin
               w_next     = S_IDLE;
               w_complete = 1'b1;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   // Frame datapath: config latch on start, LSB-first shift, running XOR and parity verdict
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         r_cfg   <= 2'b00;
         r_idx   <= '0;
         r_shift <= '0;
         r_acc   <= 1'b0;
         r_perr  <= 1'b0;
      end else if (w_step) begin
         case (r_state)
            S_IDLE: begin
               if (!i_Rx) begin
                  r_cfg  <= i_Parity;
                  r_idx  <= '0;
                  r_acc  <= 1'b0;
                  r_perr <= 1'b0;
               end
            end
            S_DATA: begin
               r_shift[r_idx] <= i_Rx;
               r_acc          <= w_acc_par;
               r_idx          <= r_idx + 1'b1;
            end
            S_PARITY: begin
               r_acc  <= w_acc_par;
               // Even mode: odd total is an error; odd mode: even total is an error
               r_perr <= (r_cfg == 2'b01) ? w_acc_par : ~w_acc_par;
            end
            default: begin
            end
         endcase
      end
   end

   // Busy tracks the state register, registered from the next state so it aligns with it
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
      end
   end

   // Host holding register with overrun pulse; a completion reload wins over a drain
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_perr_h <= 1'b0;
         r_ferr_h <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_ovr <= w_complete & r_valid & ~i_Ready;
         if (w_load) begin
            r_data   <= r_shift;
            r_perr_h <= w_par_en & r_perr;
            r_ferr_h <= w_frame_err;
            r_valid  <= 1'b1;
         end else if (r_valid & i_Ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_Data      = r_data;
   assign o_Valid     = r_valid;
   assign o_ParityErr = r_perr_h;
   assign o_FrameErr  = r_ferr_h;
   assign o_Overrun   = r_ovr;
   assign o_Busy      = r_busy;

`ifdef USRT_RX_ERRCNT_EN
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] r_fcnt;

   // Saturating error counters; dropped (overrun) frames still count
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         r_pcnt <= '0;
         r_fcnt <= '0;
      end else if (w_complete) begin
         if (w_par_en & r_perr & ~(&r_pcnt)) begin
            r_pcnt <= r_pcnt + 1'b1;
         end
         if (w_frame_err & ~(&r_fcnt)) begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   assign o_ParityErrCnt = r_pcnt;
   assign o_FrameErrCnt  = r_fcnt;
`else
   assign o_ParityErrCnt = '0;
   assign o_FrameErrCnt  = '0;
`endif

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb/tb_usrt_rx_ctrl.sv - randomized frame-level bench for usrt_rx_ctrl
module tb_usrt_rx_ctrl;

   localparam int DB = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          se;
   logic          rx;
   logic [1:0]    par;
   logic          rdy;
   logic [DB-1:0] o_Data;
   logic          o_Valid;
   logic          o_ParityErr;
   logic          o_FrameErr;
   logic          o_Overrun;
   logic          o_Busy;
   logic [CW-1:0] o_ParityErrCnt;
   logic [CW-1:0] o_FrameErrCnt;

   usrt_rx_ctrl #(.DATA_BITS(DB), .CNT_W(CW)) dut (
      .i_Pclk        (clk),
      .i_Rst_n       (rst_n),
      .i_Enable      (en),
      .i_SampleEn    (se),
      .i_Rx          (rx),
      .i_Parity      (par),
      .i_Ready       (rdy),
      .o_Data        (o_Data),
      .o_Valid       (o_Valid),
      .o_ParityErr   (o_ParityErr),
      .o_FrameErr    (o_FrameErr),
      .o_Overrun     (o_Overrun),
      .o_Busy        (o_Busy),
      .o_ParityErrCnt(o_ParityErrCnt),
      .o_FrameErrCnt (o_FrameErrCnt)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit checking    = 1'b0;
   bit rand_mode   = 1'b0;
   int gap_max     = 0;

   // Reference model: collects the sampled bits of a frame, then decodes the whole frame at once
   bit            m_valid, m_perr, m_ferr, m_ovr, m_busy;
   logic [DB-1:0] m_data;
   int            m_pcnt, m_fcnt;
   bit            collecting;
   int            nb;
   logic [1:0]    m_cfg;
   bit            mbits[0:15];

   always @(posedge clk) begin : model
      bit            done, has_par, perr, ferr;
      int            flen, ones;
      logic [DB-1:0] d;
      done = 1'b0;
      if (!rst_n) begin
         m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
         m_data = '0; m_pcnt = 0; m_fcnt = 0; collecting = 0; nb = 0; m_cfg = 2'b00;
      end else begin
         m_ovr = 1'b0;
         if (!en) begin
            collecting = 1'b0;
         end else if (se) begin
            if (!collecting) begin
               if (rx == 1'b0) begin
                  collecting = 1'b1;
                  nb         = 0;
                  m_cfg      = par;
               end
            end else begin
               mbits[nb] = rx;
               nb++;
               has_par = (m_cfg == 2'b01) || (m_cfg == 2'b10);
               flen    = DB + (has_par ? 1 : 0) + 1;
               if (nb == flen) begin
                  done       = 1'b1;
                  collecting = 1'b0;
               end
            end
         end
         if (done) begin
            has_par = (m_cfg == 2'b01) || (m_cfg == 2'b10);
            for (int i = 0; i < DB; i++) d[i] = mbits[i];
            ones = $countones(d) + (has_par ? int'(mbits[DB]) : 0);
            if (m_cfg == 2'b01)      perr = (ones % 2) == 1;
            else if (m_cfg == 2'b10) perr = (ones % 2) == 0;
            else                     perr = 1'b0;
            ferr = !mbits[nb-1];
            if (perr && m_pcnt < (1 << CW) - 1) m_pcnt++;
            if (ferr && m_fcnt < (1 << CW) - 1) m_fcnt++;
            if (!m_valid || rdy) begin
               m_valid = 1'b1; m_data = d; m_perr = perr; m_ferr = ferr;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
         m_busy = collecting;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(posedge clk) begin
      int exp_pc, exp_fc;
      #1;
      if (checking) begin
`ifdef USRT_RX_ERRCNT_EN
         exp_pc = m_pcnt; exp_fc = m_fcnt;
`else
         exp_pc = 0; exp_fc = 0;
`endif
         cmp("valid",    32'(o_Valid),        32'(m_valid));
         cmp("data",     32'(o_Data),         32'(m_data));
         cmp("perr",     32'(o_ParityErr),    32'(m_perr));
         cmp("ferr",     32'(o_FrameErr),     32'(m_ferr));
         cmp("overrun",  32'(o_Overrun),      32'(m_ovr));
         cmp("busy",     32'(o_Busy),         32'(m_busy));
         cmp("perr_cnt", 32'(o_ParityErrCnt), 32'(exp_pc));
         cmp("ferr_cnt", 32'(o_FrameErrCnt),  32'(exp_fc));
      end
   end

   task automatic idle_cycle();
      se = 1'b0;
      rx = 1'($urandom_range(0, 1));
      if (rand_mode) begin
         rdy = 1'($urandom_range(0, 1));
         en  = ($urandom_range(0, 39) != 0);
      end
      @(negedge clk);
   endtask

   // One bit strobe, optionally preceded by random idle gaps; pcfg<0 leaves i_Parity free
   task automatic strobe(input logic b, input int pcfg);
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) idle_cycle();
      en = 1'b1;
      se = 1'b1;
      rx = b;
      if (pcfg >= 0)      par = 2'(pcfg);
      else if (rand_mode) par = 2'($urandom_range(0, 3));
      if (rand_mode) rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      se = 1'b0;
      rx = 1'b1;
   endtask

   task automatic send_body(input logic [DB-1:0] d, input logic [1:0] pm, input bit bad_par);
      strobe(1'b0, int'(pm));
      for (int i = 0; i < DB; i++) strobe(d[i], -1);
      if (pm == 2'b01) strobe((^d) ^ bad_par, -1);
      if (pm == 2'b10) strobe((~^d) ^ bad_par, -1);
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input bit bad_par, input bit stop);
      send_body(d, pm, bad_par);
      strobe(stop, -1);
   endtask

   task automatic drain();
      rdy = 1'b1;
      idle_cycle();
      rdy = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; se = 1'b0; rx = 1'b1; rdy = 1'b0; par = 2'b00;
      checking = 1'b1;
      repeat (3) @(negedge clk);
      cmp("reset_valid", 32'(o_Valid), 32'd0);
      cmp("reset_data",  32'(o_Data),  32'd0);
      cmp("reset_busy",  32'(o_Busy),  32'd0);
      rst_n = 1'b1;
      idle_cycle();

      // Even parity, A5 with correct parity bit 0
      send_frame(8'hA5, 2'b01, 1'b0, 1'b1);
      cmp("t1_data",  32'(o_Data),      32'hA5);
      cmp("t1_valid", 32'(o_Valid),     32'd1);
      cmp("t1_perr",  32'(o_ParityErr), 32'd0);
      cmp("t1_ferr",  32'(o_FrameErr),  32'd0);
      drain();
      cmp("t1_drained", 32'(o_Valid), 32'd0);

      // Odd parity, 3C with parity bit 0 (wrong)
      send_frame(8'h3C, 2'b10, 1'b1, 1'b1);
      cmp("t2_data", 32'(o_Data),      32'h3C);
      cmp("t2_perr", 32'(o_ParityErr), 32'd1);
`ifdef USRT_RX_ERRCNT_EN
      cmp("t2_pcnt", 32'(o_ParityErrCnt), 32'd1);
`endif
      drain();

      // No parity, FF with stop bit 0
      send_frame(8'hFF, 2'b00, 1'b0, 1'b0);
      cmp("t3_data", 32'(o_Data),      32'hFF);
      cmp("t3_ferr", 32'(o_FrameErr),  32'd1);
      cmp("t3_perr", 32'(o_ParityErr), 32'd0);
      cmp("t3_busy", 32'(o_Busy),      32'd0);
      drain();

      // Overrun then reload on the draining edge
      send_frame(8'h11, 2'b00, 1'b0, 1'b1);
      send_frame(8'h22, 2'b00, 1'b0, 1'b1);
      cmp("t4_ovr_pulse", 32'(o_Overrun), 32'd1);
      cmp("t4_held",      32'(o_Data),    32'h11);
      idle_cycle();
      cmp("t4_ovr_end",   32'(o_Overrun), 32'd0);
      send_body(8'h33, 2'b00, 1'b0);
      rdy = 1'b1;
      strobe(1'b1, -1);
      rdy = 1'b0;
      cmp("t4_reload_data",  32'(o_Data),  32'h33);
      cmp("t4_reload_valid", 32'(o_Valid), 32'd1);

      // Reset mid-frame with a byte still held
      strobe(1'b0, 0);
      for (int i = 0; i < 4; i++) strobe(1'b1, -1);
      rst_n = 1'b0;
      idle_cycle();
      cmp("t5_valid", 32'(o_Valid), 32'd0);
      cmp("t5_data",  32'(o_Data),  32'd0);
      cmp("t5_busy",  32'(o_Busy),  32'd0);
      rst_n = 1'b1;
      send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
      cmp("t5_next_data", 32'(o_Data), 32'h5A);
      cmp("t5_next_ferr", 32'(o_FrameErr), 32'd0);
      drain();

      // Randomized frames: random gaps, ready, enable drops and mid-frame parity changes
      rand_mode = 1'b1;
      gap_max   = 2;
      for (int k = 0; k < 200; k++) begin
         logic [DB-1:0] d;
         logic [1:0]    pm;
         d  = DB'($urandom);
         pm = 2'($urandom_range(0, 3));
         send_frame(d, pm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      end
      rand_mode = 1'b0;
      gap_max   = 0;
      en        = 1'b1;
      drain();

      // Frame-error counter saturation
      rdy = 1'b1;
      for (int k = 0; k < 300; k++) send_frame(8'hFF, 2'b00, 1'b0, 1'b0);
`ifdef USRT_RX_ERRCNT_EN
      cmp("t6_fcnt_sat", 32'(o_FrameErrCnt), 32'hFF);
`else
      cmp("t6_fcnt_off", 32'(o_FrameErrCnt), 32'h0);
`endif
      rdy = 1'b0;
      repeat (4) idle_cycle();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
